// File: rtl/fifo_1r1w_sync.sv
// Single-clock 1R1W FIFO with valid/ready, occupancy count, almost-full/empty flags and high-water mark.
// Define FIFO_1R1W_SYNC_FLUSH_EN to add the synchronous flush_i port.
module fifo_1r1w_sync #(
  parameter int unsigned width_p         = 32,
  parameter int unsigned depth_log2_p    = 4,
  parameter int          afull_thresh_p  = (1 << depth_log2_p) - 1,
  parameter int          aempty_thresh_p = 1
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
`ifdef FIFO_1R1W_SYNC_FLUSH_EN
  input  logic                    flush_i,
`endif
  input  logic [width_p-1:0]      data_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic                    valid_o,
  output logic [width_p-1:0]      data_o,
  input  logic                    ready_i,
  output logic [depth_log2_p:0]   count_o,
  output logic                    almost_full_o,
  output logic                    almost_empty_o,
  output logic [depth_log2_p:0]   hwm_o
);

  localparam int unsigned depth_lp = 1 << depth_log2_p;

  typedef logic [depth_log2_p:0]   ptr_t;
  typedef logic [depth_log2_p-1:0] addr_t;

  logic [width_p-1:0] mem_q [depth_lp];
  logic [width_p-1:0] data_q, data_n;
  ptr_t  wr_ptr_q, wr_ptr_n;
  ptr_t  rd_ptr_q, rd_ptr_n;
  ptr_t  count_q, count_n;
  ptr_t  hwm_q, hwm_n;
  addr_t wr_addr, rd_addr_n;
  logic  full, empty, do_write, do_read, flush, fwd;

`ifdef FIFO_1R1W_SYNC_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  assign wr_addr  = wr_ptr_q[depth_log2_p-1:0];
  assign full     = (wr_ptr_q[depth_log2_p] != rd_ptr_q[depth_log2_p]) &&
                    (wr_addr == rd_ptr_q[depth_log2_p-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign do_write = valid_i & ~full;
  assign do_read  = ready_i & ~empty;

  always_comb begin
    wr_ptr_n = wr_ptr_q + ptr_t'(do_write);
    rd_ptr_n = rd_ptr_q + ptr_t'(do_read);
    if (flush) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
    end
    count_n   = wr_ptr_n - rd_ptr_n;
    hwm_n     = (count_n > hwm_q) ? count_n : hwm_q;
    rd_addr_n = rd_ptr_n[depth_log2_p-1:0];
    // Storage is read one cycle ahead; a write landing in the next head slot
    // is forwarded since the array still holds stale data there.
    fwd    = do_write && (wr_addr == rd_addr_n);
    data_n = fwd ? data_i : mem_q[rd_addr_n];
  end

  always_ff @(posedge clk_i) begin
    if (do_write) begin
      mem_q[wr_addr] <= data_i;
    end
    data_q <= data_n;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hwm_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_n;
      rd_ptr_q <= rd_ptr_n;
      count_q  <= count_n;
      hwm_q    <= hwm_n;
    end
  end

  assign ready_o        = ~full;
  assign valid_o        = ~empty;
  assign data_o         = data_q;
  assign count_o        = count_q;
  assign hwm_o          = hwm_q;
  assign almost_full_o  = int'(count_q) >= afull_thresh_p;
  assign almost_empty_o = int'(count_q) <= aempty_thresh_p;

endmodule

// File: doc/fifo_1r1w_sync.md
# fifo_1r1w_sync

Single-clock, parametrised 1-read/1-write FIFO with valid/ready on both sides, occupancy count, programmable almost-full/almost-empty flags and a high-water-mark register. It is the same-clock companion of the dual-clock FIFO and is used wherever producer and consumer share one clock but need buffering, back-pressure and fill-level telemetry. Pointers are binary, with one extra wrap bit. Storage is a power-of-two array.

## Interface
- width_p, 32, data width in bits (>= 1)
- depth_log2_p, 4, log2 of entry count; depth = 2**depth_log2_p (>= 1)
- afull_thresh_p, (1<<depth_log2_p)-1, almost_full_o asserts when count >= this value
- aempty_thresh_p, 1, almost_empty_o asserts when count <= this value
- clk_i  input  1  single clock; all state updates on posedge
- reset_ni  input  1  synchronous active-low reset (one clock; reset is synchronous and active-low)
- data_i  input  width_p  write data
- valid_i  input  1  write request
- ready_o  output  1  FIFO can accept; write occurs when valid_i & ready_o
- valid_o  output  1  read data available
- data_o  output  width_p  head-of-FIFO data, meaningful when valid_o
- ready_i  input  1  consumer accepts; read occurs when valid_o & ready_i
- count_o  output  depth_log2_p+1  current occupancy, 0..depth
- almost_full_o  output  1  count_o >= afull_thresh_p
- almost_empty_o  output  1  count_o <= aempty_thresh_p
- hwm_o  output  depth_log2_p+1  highest count_o reached since reset
- flush_i  input  1  present only with FIFO_1R1W_SYNC_FLUSH_EN; synchronous clear

## Operation
- wr_ptr and rd_ptr are (depth_log2_p+1)-bit counters; the low bits address storage; the MSB is the wrap bit; both wrap modulo 2**(depth_log2_p+1)
- full: MSBs differ and low bits are equal. empty: pointers are equal. count_o = wr_ptr - rd_ptr, modulo the pointer width, registered or derived from registers only
- ready_o = ~full and depends only on state. No combinational path from ready_i, so a write is refused when full even if a read happens the same cycle
- valid_o = ~empty and depends only on state. No path from valid_i, so there is no same-cycle fall-through when empty
- Write: data_i is stored at wr_ptr and wr_ptr increments. Read: rd_ptr increments and data_o presents the next entry
- Simultaneous write and read when neither full nor empty: both pointers advance and count_o is unchanged
- data_o must show the entry at rd_ptr in every cycle where valid_o=1, including the cycle right after a read. With synchronous storage, the read address is looked ahead (rd_ptr+1 on read) and a write-to-read forward is required when the written slot is the next to be read
- hwm_o is updated each cycle to max(hwm_o, next count). It never decreases except on reset
- Flags are recomputed from count each cycle. With a threshold outside 0..depth the flag is constant, which is legal

## Timing
- Reset (reset_ni=0 at a posedge): pointers=0, count_o=0, hwm_o=0, valid_o=0, ready_o=1, almost_empty_o=1 (if aempty_thresh_p>=0), almost_full_o=(afull_thresh_p==0). data_o is don't-care
- Reset has priority over any concurrent handshake. A transfer in the reset cycle is discarded
- Write latency: data accepted at edge t gives valid_o=1 and data_o=that data in the cycle following edge t
- Full-to-ready latency: a read at edge t gives ready_o=1 in the cycle following t
- All outputs change only after posedge clk_i. Throughput is 1 write + 1 read per cycle sustained

## Configuration
- FIFO_1R1W_SYNC_FLUSH_EN defined: the flush_i port exists. flush_i=1 at a posedge sets both pointers to 0 and count to 0, and discards any same-cycle write or read. hwm_o is not cleared. reset_ni=0 still overrides
- Not defined: the flush_i port is absent, and only reset_ni empties the FIFO

## Test plan
- Reset, then write 0x11,0x22,0x33 on back-to-back cycles with ready_i=0 -> valid_o=1 one cycle after the first write, count_o=3, data_o=0x11, hwm_o=3
- depth_log2_p=2: write 4 words -> ready_o=0 and count_o=4. A 5th write with valid_i=1 is ignored. Read one -> ready_o=1 the next cycle
- Continuous write+read of an incrementing pattern for 3*depth cycles (pointer wrap twice) -> data_o in order, no gaps, count_o constant
- Empty FIFO with simultaneous valid_i=1, ready_i=1 -> no read that cycle, valid_o=1 next cycle
- Fill to 3 with afull_thresh_p=3, aempty_thresh_p=1 -> almost_full_o=1. Drain to 1 -> almost_empty_o=1 and hwm_o stays 3
- With FIFO_1R1W_SYNC_FLUSH_EN: fill to 2, assert flush_i with valid_i=1 -> next cycle count_o=0, valid_o=0, hwm_o=2. Assert reset_ni=0 mid-stream -> all outputs at reset values next cycle
